// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results straight through to MEM/WB and runs
// loads/stores as single-beat AXI4 transactions, holding EX/MEM while busy.
module mem_access #(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   // EX/MEM register
   input  logic [4:0]    rd_addr_i,
   input  logic [63:0]   rd_data_i,
   input  logic          rd_wen_i,
   input  logic          read_ram_i,
   input  logic          write_ram_i,
   input  logic [31:0]   inst_i,
   input  logic [63:0]   inst_addr_i,
   input  logic [AW-1:0] id_axi_araddr_i,
   input  logic [63:0]   op2_i,
   // MEM/WB register
   output logic [4:0]    rd_addr_o,
   output logic [63:0]   rd_data_o,
   output logic          rd_wen_o,
   output logic [31:0]   inst_o,
   output logic [63:0]   inst_addr_o,
   // pipeline control and status
   output logic          mem_en_o,
   output logic          misalign_o,
   output logic          bus_err_o,
   // AR channel
   output logic [AW-1:0] araddr,
   output logic [2:0]    arsize,
   output logic [7:0]    arlen,
   output logic [1:0]    arburst,
   output logic          arvalid,
   input  logic          arready,
   // R channel
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    rresp,
   input  logic          rvalid,
   output logic          rready,
   // AW channel
   output logic [AW-1:0] awaddr,
   output logic [2:0]    awsize,
   output logic [7:0]    awlen,
   output logic [1:0]    awburst,
   output logic          awvalid,
   input  logic          awready,
   // W channel
   output logic [DW-1:0] wdata,
   output logic [7:0]    wstrb,
   output logic          wlast,
   output logic          wvalid,
   input  logic          wready,
   // B channel
   input  logic [1:0]    bresp,
   input  logic          bvalid,
   output logic          bready
);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_addr;
   logic [2:0]      r_funct3;
   logic            r_is_load;
   logic            r_aw_done;
   logic            r_w_done;
   logic [63:0]     r_load_data;
   logic [DW-1:0]   r_wdata;
   logic [7:0]      r_wstrb;

   logic [2:0]      w_funct3;
   logic [2:0]      w_off;
   logic            w_req;
   logic            w_misalign;
   logic            w_launch;
   logic            w_aw_fire;
   logic            w_w_fire;
   logic            w_r_fire;
   logic            w_b_fire;
   logic [63:0]     w_lane;
   logic [63:0]     w_load_ext;
   logic [DW-1:0]   w_store_data;
   logic [7:0]      w_store_strb;

   assign w_funct3  = inst_i[14:12];
   assign w_off     = id_axi_araddr_i[2:0];
   // A load takes priority when both flags are set.
   assign w_req     = read_ram_i | write_ram_i;
   assign w_launch  = (r_state == S_IDLE) && w_req && !w_misalign;
   assign w_aw_fire = awvalid & awready;
   assign w_w_fire  = wvalid & wready;
   assign w_r_fire  = rready & rvalid;
   assign w_b_fire  = bready & bvalid;
   assign w_lane    = rdata >> {r_addr[2:0], 3'b000};

   // Alignment check by access size (funct3[1:0] = log2 of byte count).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_misalign = 1'b0;
      unique case (w_funct3[1:0])
         2'b00: w_misalign = 1'b0;
         2'b01: w_misalign = w_off[0];
         2'b10: w_misalign = |w_off[1:0];
         2'b11: w_misalign = |w_off;
      endcase
   end

   // Store data is replicated across lanes; strobes select the addressed bytes.
   always_comb begin
      w_store_data = op2_i;
      w_store_strb = 8'hFF;
      unique case (w_funct3[1:0])
         2'b00: begin w_store_data = {8{op2_i[7:0]}};  w_store_strb = 8'h01 << w_off; end
         2'b01: begin w_store_data = {4{op2_i[15:0]}}; w_store_strb = 8'h03 << w_off; end
         2'b10: begin w_store_data = {2{op2_i[31:0]}}; w_store_strb = 8'h0F << w_off; end
         2'b11: begin w_store_data = op2_i;            w_store_strb = 8'hFF;          end
      endcase
   end

   // Load lane sign/zero extension according to the latched funct3.
   always_comb begin
      w_load_ext = w_lane;
      case (r_funct3)
         3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
         3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
         3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
         3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
         3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
         default: w_load_ext = w_lane;
      endcase
   end

   // State register plus the access context captured at launch, so bus
   // address/data stay stable regardless of upstream behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_funct3    <= '0;
         r_is_load   <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_load_data <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         r_state <= w_next;
         if (w_launch) begin
            r_addr    <= id_axi_araddr_i;
            r_funct3  <= w_funct3;
            r_is_load <= read_ram_i;
            r_wdata   <= w_store_data;
            r_wstrb   <= w_store_strb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_fire) r_aw_done   <= 1'b1;
         if (w_w_fire)  r_w_done    <= 1'b1;
         if (w_r_fire)  r_load_data <= w_load_ext;
      end
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_launch) w_next = read_ram_i ? S_RADDR : S_WREQ;
         S_RADDR: if (arready)  w_next = S_RDATA;
         S_RDATA: if (rvalid)   w_next = S_DONE;
         S_WREQ:  if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_WRESP;
         S_WRESP: if (bvalid)   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Pipeline hold and writeback enable: held while any access is in flight.
   always_comb begin
      mem_en_o = 1'b0;
      rd_wen_o = rd_wen_i;
      unique case (r_state)
         S_IDLE: if (w_req) begin
            rd_wen_o = 1'b0;
            mem_en_o = !w_misalign;
         end
         S_DONE: ;
         default: begin
            mem_en_o = 1'b1;
            rd_wen_o = 1'b0;
         end
      endcase
   end

   assign rd_addr_o   = rd_addr_i;
   assign inst_o      = inst_i;
   assign inst_addr_o = inst_addr_i;
   assign rd_data_o   = (r_state == S_DONE && r_is_load) ? r_load_data : rd_data_i;
   assign misalign_o  = (r_state == S_IDLE) && w_req && w_misalign;
   assign bus_err_o   = (w_r_fire && rresp != RESP_OKAY) || (w_b_fire && bresp != RESP_OKAY);

   assign araddr  = r_addr;
   assign arsize  = {1'b0, r_funct3[1:0]};
   assign arlen   = 8'd0;
   assign arburst = BURST_INCR;
   assign arvalid = (r_state == S_RADDR);
   assign rready  = (r_state == S_RDATA);

   assign awaddr  = r_addr;
   assign awsize  = {1'b0, r_funct3[1:0]};
   assign awlen   = 8'd0;
   assign awburst = BURST_INCR;
   assign awvalid = (r_state == S_WREQ) && !r_aw_done;
   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign wlast   = 1'b1;
   assign wvalid  = (r_state == S_WREQ) && !r_w_done;
   assign bready  = (r_state == S_WRESP);

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random traffic
// compared against a byte-level transaction model with a delay-driven slave.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic [63:0] rd_data_i = '0;
   logic        rd_wen_i = 1'b0;
   logic        read_ram_i = 1'b0;
   logic        write_ram_i = 1'b0;
   logic [31:0] inst_i = '0;
   logic [63:0] inst_addr_i = '0;
   logic [31:0] id_axi_araddr_i = '0;
   logic [63:0] op2_i = '0;
   logic [4:0]  rd_addr_o;
   logic [63:0] rd_data_o;
   logic        rd_wen_o;
   logic [31:0] inst_o;
   logic [63:0] inst_addr_o;
   logic        mem_en_o, misalign_o, bus_err_o;
   logic [31:0] araddr, awaddr;
   logic [2:0]  arsize, awsize;
   logic [7:0]  arlen, awlen;
   logic [1:0]  arburst, awburst;
   logic        arvalid, rready, awvalid, wvalid, wlast, bready;
   logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [63:0] rdata = '0;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic [1:0]  rresp = '0, bresp = '0;

   int n_checks = 0;
   int n_errors = 0;

   mem_access #(.AW(32), .DW(64)) dut (
      .clk(clk), .rst(rst),
      .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
      .read_ram_i(read_ram_i), .write_ram_i(write_ram_i),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .id_axi_araddr_i(id_axi_araddr_i), .op2_i(op2_i),
      .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .mem_en_o(mem_en_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic slave_idle();
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
   endtask

   // Presents one EX/MEM entry, plays the AXI slave with the given delays and
   // checks everything against the transaction model until the access retires.
   task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [63:0] op2,
                             input logic [63:0] rd_v, input logic [1:0] resp,
                             input int d_a, input int d_w, input int d_d);
      int n, off, held, exp_held, berr, ar_c, r_c, aw_c, w_c, b_c;
      bit mis, done;
      logic [63:0] exp_ld, exp_wd, rdi;
      logic [7:0]  exp_strb;
      logic        rwen;
      rdi  = {$urandom, $urandom};
      rwen = 1'($urandom_range(0, 1));
      @(negedge clk);
      slave_idle();
      rd_addr_i       = 5'($urandom);
      rd_data_i       = rdi;
      rd_wen_i        = rwen;
      read_ram_i      = ld;
      write_ram_i     = st;
      inst_i          = {17'($urandom), f3, 12'($urandom)};
      inst_addr_i     = {$urandom, $urandom};
      id_axi_araddr_i = addr;
      op2_i           = op2;
      n   = 1 << f3[1:0];
      off = int'(addr[2:0]);
      mis = (off % n) != 0;
      if (!ld && !st) begin
         #1;
         check("pass_wen", rd_wen_o, rwen);
         check("pass_data", rd_data_o, rdi);
         check("pass_inst", {rd_addr_o, inst_o}, {rd_addr_i, inst_i});
         check("pass_pc", inst_addr_o, inst_addr_i);
         check("pass_ctl", {mem_en_o, misalign_o, arvalid, awvalid, wvalid}, 0);
         return;
      end
      if (mis) begin
         #1;
         check("mis_pulse", misalign_o, 1);
         check("mis_ctl", {mem_en_o, rd_wen_o, arvalid, awvalid, wvalid}, 0);
         @(negedge clk);
         read_ram_i = 1'b0; write_ram_i = 1'b0;
         #1;
         check("mis_end", {misalign_o, arvalid, awvalid, wvalid, mem_en_o}, 0);
         return;
      end
      // Model: assemble the addressed bytes little-endian, then extend.
      exp_ld = '0;
      for (int k = 0; k < n; k++) exp_ld |= 64'(rd_v[8*(off+k) +: 8]) << (8*k);
      if (!f3[2] && n < 8 && exp_ld[8*n-1]) exp_ld |= ~64'd0 << (8*n);
      for (int j = 0; j < 8; j++) begin
         exp_wd[8*j +: 8] = op2[8*(j % n) +: 8];
         exp_strb[j]      = (j >= off) && (j < off + n);
      end
      exp_held = ld ? 3 + d_a + d_d : 3 + ((d_a > d_w) ? d_a : d_w) + d_d;
      held = 0; berr = 0; done = 0;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         arready = arvalid && (ar_c >= d_a);
         rvalid  = rready && (r_c >= d_d);
         rdata   = rd_v;
         rresp   = resp;
         awready = awvalid && (aw_c >= d_a);
         wready  = wvalid && (w_c >= d_w);
         bvalid  = bready && (b_c >= d_d);
         bresp   = resp;
         #1;
         if (bus_err_o) berr++;
         if (mem_en_o) begin
            held++;
            check("hold_wen", rd_wen_o, 0);
         end else if (cyc > 0) begin
            done = 1;
            check("done_wen", rd_wen_o, rwen);
            check("done_data", rd_data_o, ld ? exp_ld : rdi);
            check("held_cycles", 64'(held), 64'(exp_held));
            check("bus_err", 64'(berr), 64'(resp != 2'b00));
         end else begin
            check("launch_hold", mem_en_o, 1);
         end
         check("direction", ld ? {awvalid, wvalid, bready} : {1'b0, arvalid, rready}, 0);
         if (arvalid) begin
            check("ar_addr", araddr, addr);
            check("ar_ctl", {arsize, arlen, arburst}, {1'b0, f3[1:0], 8'd0, 2'b01});
            ar_c++;
         end
         if (rready) r_c++;
         if (awvalid) begin
            check("aw_addr", awaddr, addr);
            check("aw_ctl", {awsize, awlen, awburst}, {1'b0, f3[1:0], 8'd0, 2'b01});
            aw_c++;
         end
         if (wvalid) begin
            check("w_data", wdata, exp_wd);
            check("w_strb", {wlast, wstrb}, {1'b1, exp_strb});
            w_c++;
         end
         if (bready) b_c++;
      end
      if (!done) check("timeout", 0, 1);
      slave_idle();
   endtask

   // Abandons a load in RDATA by asserting reset mid-cycle.
   task automatic reset_mid_read();
      @(negedge clk);
      slave_idle();
      read_ram_i = 1'b1; write_ram_i = 1'b0; rd_wen_i = 1'b1;
      inst_i = 32'h0000_3003; id_axi_araddr_i = 32'h8000_0010;
      arready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_in_rdata", rready, 1);
      #1 rst = 1'b0;
      #1;
      check("rst_valids", {rready, arvalid, awvalid, wvalid, bready}, 0);
      check("rst_mem_en_req", mem_en_o, 1);
      read_ram_i = 1'b0;
      slave_idle();
      #1;
      check("rst_mem_en_nop", mem_en_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst", {mem_en_o, rd_wen_o, arvalid, rready}, 4'b0100);
   endtask

   initial begin
      int kind;
      logic [2:0] f3;
      rd_data_i = 64'h0000_0000_0000_1234;
      rd_wen_i  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_valids", {arvalid, rready, awvalid, wvalid, bready, misalign_o, bus_err_o, mem_en_o}, 0);
      check("reset_pass", rd_data_o, 64'h1234);
      rst = 1'b1;

      // Directed cases from the block's intended use.
      run_access(0, 0, 3'b000, 32'h0, 64'h0, 64'h0, 2'b00, 0, 0, 0);
      run_access(1, 0, 3'b000, 32'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0);
      run_access(0, 1, 3'b001, 32'h8000_0006, 64'hBEEF, 64'h0, 2'b00, 2, 0, 1);
      run_access(1, 0, 3'b010, 32'h8000_0002, 64'h0, 64'h0, 2'b00, 0, 0, 0);
      run_access(1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 0, 5);
      run_access(1, 1, 3'b110, 32'h8000_0004, 64'h1, 64'hF00D_CAFE_0000_0000, 2'b00, 1, 0, 0);
      run_access(0, 1, 3'b011, 32'h8000_0018, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 2'b11, 0, 3, 2);
      reset_mid_read();

      // Random traffic.
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 3);
         f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
         run_access(kind == 1 || kind == 3, kind >= 2, f3,
                    {1'b1, 28'($urandom), 3'($urandom)}, {$urandom, $urandom},
                    {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
